// File: rtl/dht11_sensor_emu.sv
`default_nettype none
// dht11_sensor_emu: open-drain DHT11 sensor model that answers a host start pulse with a 40-bit frame.
// Rev 1.0 - initial release.
module dht11_sensor_emu #(
  parameter int START_MIN_CYC = 1000000,
  parameter int T_WAIT_CYC    = 3000,
  parameter int T_RESP_CYC    = 8000,
  parameter int T_BIT_LOW_CYC = 5000,
  parameter int T_ZERO_CYC    = 2700,
  parameter int T_ONE_CYC     = 7000
) (
  input  logic       CLK,
  input  logic       RST,
  inout  wire        DHT_DATA,
  input  logic [7:0] HUM_INT,
  input  logic [7:0] HUM_FLOAT,
  input  logic [7:0] TEMP_INT,
  input  logic [7:0] TEMP_FLOAT,
  output logic       BUSY,
  output logic       FRAME_DONE
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HLOW  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RLOW  = 3'd3;
  localparam logic [2:0] S_RHIGH = 3'd4;
  localparam logic [2:0] S_BLOW  = 3'd5;
  localparam logic [2:0] S_BHIGH = 3'd6;
  localparam logic [2:0] S_ELOW  = 3'd7;

  localparam logic [20:0] c_start_min = 21'(START_MIN_CYC);
  localparam logic [20:0] c_wait_last = 21'(T_WAIT_CYC - 1);
  localparam logic [20:0] c_resp_last = 21'(T_RESP_CYC - 1);
  localparam logic [20:0] c_blow_last = 21'(T_BIT_LOW_CYC - 1);
  localparam logic [20:0] c_zero_last = 21'(T_ZERO_CYC - 1);
  localparam logic [20:0] c_one_last  = 21'(T_ONE_CYC - 1);
  localparam logic [5:0]  c_last_bit  = 6'd39;

  logic [2:0]  state_q, state_d;
  logic [20:0] cnt_q, cnt_d;
  logic [5:0]  bit_q, bit_d;
  logic [39:0] frame_q, frame_d;
  logic        armed_q, armed_d;
  logic        sync1_q, sync2_q;
  logic        drive_low;
  logic [7:0]  checksum;
  logic [5:0]  bit_pos;
  logic        cur_bit;
  logic [20:0] high_last;

  assign checksum  = HUM_INT + HUM_FLOAT + TEMP_INT + TEMP_FLOAT;
  assign bit_pos   = c_last_bit - bit_q;
  assign cur_bit   = frame_q[bit_pos];
  assign high_last = cur_bit ? c_one_last : c_zero_last;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      armed_q <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      armed_q <= armed_d;
      sync1_q <= DHT_DATA;
      sync2_q <= sync1_q;
    end
  end

  // Only IDLE and HLOW look at the bus; everything from WAIT on runs purely on the counter.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    armed_d = armed_q;
    case (state_q)
      S_IDLE: begin
        if (sync2_q)      armed_d = 1'b1;
        else if (armed_q) state_d = S_HLOW;
      end
      S_HLOW: begin
        if (sync2_q) state_d = (cnt_q >= c_start_min) ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (cnt_q == c_wait_last) begin
          state_d = S_RLOW;
          frame_d = {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, checksum};
        end
      end
      S_RLOW: begin
        if (cnt_q == c_resp_last) state_d = S_RHIGH;
      end
      S_RHIGH: begin
        if (cnt_q == c_resp_last) begin
          state_d = S_BLOW;
          bit_d   = '0;
        end
      end
      S_BLOW: begin
        if (cnt_q == c_blow_last) state_d = S_BHIGH;
      end
      S_BHIGH: begin
        if (cnt_q == high_last) begin
          if (bit_q == c_last_bit) begin
            state_d = S_ELOW;
          end else begin
            state_d = S_BLOW;
            bit_d   = bit_q + 6'd1;
          end
        end
      end
      S_ELOW: begin
        // Our own low is still in the synchronizer; re-arm only after a high is seen.
        if (cnt_q == c_blow_last) begin
          state_d = S_IDLE;
          armed_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q)  cnt_d = '0;
    else if (state_q == S_IDLE) cnt_d = '0;
    else if (state_q == S_HLOW) cnt_d = (cnt_q >= c_start_min) ? cnt_q : cnt_q + 21'd1;
    else                        cnt_d = cnt_q + 21'd1;
  end

  always_comb begin
    drive_low  = 1'b0;
    BUSY       = 1'b1;
    FRAME_DONE = 1'b0;
    case (state_q)
      S_IDLE, S_HLOW:         BUSY = 1'b0;
      S_RLOW, S_BLOW:         drive_low = 1'b1;
      S_ELOW: begin
        drive_low  = 1'b1;
        FRAME_DONE = (cnt_q == c_blow_last);
      end
      default: ;
    endcase
  end

  assign DHT_DATA = drive_low ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_dht11_sensor_emu.sv
`default_nettype none
// tb_dht11_sensor_emu: randomized frames checked cycle-by-cycle against a waveform model.
// Rev 1.0 - initial release.
module tb_dht11_sensor_emu;

  localparam int START = 200;
  localparam int TW    = 30;
  localparam int TR    = 80;
  localparam int TBL   = 50;
  localparam int T0    = 27;
  localparam int T1    = 70;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_low = 1'b0;
  logic [7:0] hi = '0, hf = '0, ti = '0, tf = '0;
  logic       busy, done;
  wire        dht;

  assign dht = host_low ? 1'b0 : 1'bz;
  pullup (dht);

  always #5 clk = ~clk;

  dht11_sensor_emu #(
    .START_MIN_CYC(START), .T_WAIT_CYC(TW), .T_RESP_CYC(TR),
    .T_BIT_LOW_CYC(TBL), .T_ZERO_CYC(T0), .T_ONE_CYC(T1)
  ) dut (
    .CLK(clk), .RST(rst), .DHT_DATA(dht),
    .HUM_INT(hi), .HUM_FLOAT(hf), .TEMP_INT(ti), .TEMP_FLOAT(tf),
    .BUSY(busy), .FRAME_DONE(done)
  );

  int tests = 0;
  int fails = 0;

  logic [2:0]  exp_q[$];   // per sample {sensor drives low, BUSY, FRAME_DONE}
  logic        cap_low[$];
  logic [39:0] exp_frame;
  logic        mon_on = 1'b0;
  int          mon_k = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, expv);
    end
  endtask

  function automatic void push_run(input int n, input logic low, input logic bsy);
    for (int i = 0; i < n; i++) exp_q.push_back({low, bsy, 1'b0});
  endfunction

  // Expected bus waveform from host release: 2 synchronizer cycles, then WAIT .. ELOW, then idle tail.
  function automatic void build_expect(input logic [7:0] a, b, c, d);
    int cs;
    cs = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
    exp_frame = {a, b, c, d, cs[7:0]};
    exp_q.delete();
    push_run(2, 1'b0, 1'b0);
    push_run(TW, 1'b0, 1'b1);
    push_run(TR, 1'b1, 1'b1);
    push_run(TR, 1'b0, 1'b1);
    for (int i = 39; i >= 0; i--) begin
      push_run(TBL, 1'b1, 1'b1);
      push_run(exp_frame[i] ? T1 : T0, 1'b0, 1'b1);
    end
    push_run(TBL, 1'b1, 1'b1);
    exp_q[exp_q.size() - 1] = 3'b111;
    push_run(6, 1'b0, 1'b0);
  endfunction

  function automatic int bit_start(input int b);
    int idx;
    idx = 2 + TW + 2 * TR;
    for (int i = 0; i < b; i++) idx += TBL + (exp_frame[39 - i] ? T1 : T0);
    return idx;
  endfunction

  function automatic logic [39:0] decode();
    int p;
    int len;
    logic [39:0] r;
    p = 0;
    r = '0;
    while (p < cap_low.size() && !cap_low[p]) p++;
    while (p < cap_low.size() && cap_low[p]) p++;
    while (p < cap_low.size() && !cap_low[p]) p++;
    for (int i = 39; i >= 0; i--) begin
      while (p < cap_low.size() && cap_low[p]) p++;
      len = 0;
      while (p < cap_low.size() && !cap_low[p]) begin p++; len++; end
      r[i] = (len > (T0 + T1) / 2);
    end
    return r;
  endfunction

  always @(posedge clk) begin : monitor
    logic [2:0] e;
    logic       dl;
    #1;
    if (!mon_on) begin
      mon_k = 0;
    end else if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      dl = (dht === 1'b0) && !host_low;
      cap_low.push_back(dl);
      if (host_low) check($sformatf("wave_busy_done[%0d]", mon_k), {62'd0, busy, done}, {62'd0, e[1:0]});
      else          check($sformatf("wave[%0d]", mon_k), {61'd0, dl, busy, done}, {61'd0, e});
      mon_k++;
    end
  end

  // ev_kind: 0 none, 1 TEMP_INT <= 0x20 at sample ev_at, 2 host pulls low 20 cycles, 3 reset pulse.
  task automatic do_frame(input logic [7:0] a, b, c, d, input int hold, input int ev_kind, input int ev_at);
    int guard;
    hi = a; hf = b; ti = c; tf = d;
    build_expect(a, b, c, d);
    cap_low.delete();
    @(negedge clk);
    host_low = 1'b1;
    repeat (hold - 1) @(negedge clk);
    check("hold_busy", {63'd0, busy}, 64'd0);
    host_low = 1'b0;
    mon_on   = 1'b1;
    guard    = 0;
    while (exp_q.size() != 0 && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (ev_kind == 1 && mon_k == ev_at) ti = 8'h20;
      if (ev_kind == 2 && mon_k == ev_at) host_low = 1'b1;
      if (ev_kind == 2 && mon_k == ev_at + 20) host_low = 1'b0;
      if (ev_kind == 3 && mon_k == ev_at) begin
        rst = 1'b1;
        #1;
        check("reset_release", {62'd0, dht === 1'b1, busy}, 64'd2);
        check("reset_done", {63'd0, done}, 64'd0);
        mon_on = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_idle", {62'd0, dht === 1'b1, busy}, 64'd2);
        return;
      end
    end
    if (exp_q.size() != 0) check("frame_timeout", 64'(exp_q.size()), 64'd0);
    mon_on = 1'b0;
    exp_q.delete();
    host_low = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [7:0] r0, r1, r2, r3;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {61'd0, dht === 1'b1, busy, done}, 64'd4);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    do_frame(8'h37, 8'h00, 8'h19, 8'h00, 360, 0, 0);
    check("frame_3700190050", {24'd0, decode()}, {24'd0, 40'h37_00_19_00_50});

    do_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 300, 0, 0);
    check("frame_all_ff", {24'd0, decode()}, {24'd0, 40'hFF_FF_FF_FF_FC});

    @(negedge clk);
    host_low = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      check("short_hold_busy", {63'd0, busy}, 64'd0);
    end
    @(negedge clk);
    host_low = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      check("short_no_reply", {61'd0, dht === 1'b1, busy, done}, 64'd4);
    end

    build_expect(8'h37, 8'h00, 8'h19, 8'h00);
    do_frame(8'h37, 8'h00, 8'h19, 8'h00, 280, 1, bit_start(5) + 10);
    check("latched_temp", {24'd0, decode()}, {24'd0, 40'h37_00_19_00_50});
    check("temp_changed", {56'd0, ti}, 64'h20);

    r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
    do_frame(r0, r1, r2, r3, 250, 2, 2 + TW + TR + 18);
    check("pull_in_rhigh", {24'd0, decode()}, {24'd0, exp_frame});

    build_expect(8'h37, 8'h00, 8'h19, 8'h00);
    do_frame(8'h37, 8'h00, 8'h19, 8'h00, 300, 3, bit_start(20) + 10);
    do_frame(8'h37, 8'h00, 8'h19, 8'h00, 300, 0, 0);
    check("after_reset", {24'd0, decode()}, {24'd0, 40'h37_00_19_00_50});

    for (int n = 0; n < 4; n++) begin
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
      do_frame(r0, r1, r2, r3, $urandom_range(220, 400), 0, 0);
      check($sformatf("random_frame%0d", n), {24'd0, decode()}, {24'd0, exp_frame});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
